wand_bus_tx: RTL

- Transmitter end of the team's wired-AND (wand/open-drain) shared line.
- Serialises one DATA_W word onto the line as a start bit, then data MSB-first, then a stop bit.
- Reads back the resolved line level each bit and performs bitwise arbitration: a transmitter that releases the line while another node holds it low loses.
- Several instances drive one wand net; each sees the resolved value on bus_in.

---
 rtl/wand_bus_pkg.sv | 18 +
 rtl/wand_bus_bit_timer.sv | 39 +++
 rtl/wand_bus_tx.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/wand_bus_pkg.sv
// Shared types and constants for the wired-AND line transmitter.
package wand_bus_pkg;

    localparam int unsigned DATA_W_DEF     = 8;
    localparam int unsigned BIT_CYCLES_DEF = 4;

    // Resolved line levels as seen on bus_in.
    localparam logic BUS_RELEASED = 1'b1;
    localparam logic BUS_LOW      = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

endpackage

// File: rtl/wand_bus_bit_timer.sv
// Per-bit cycle counter; sample_tick marks the last cycle of each bit.
module wand_bus_bit_timer #(
    parameter int unsigned BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic sample_tick
);

    localparam int unsigned        CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(BIT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_tick;

    // Wrap at LAST so each bit lasts exactly BIT_CYCLES cycles.
    always_comb begin
        w_count_nxt = r_count + CNT_W'(1);
        if (clear || (r_count == LAST)) begin
            w_count_nxt = '0;
        end
    end

    // Tick is registered from the next count so it coincides with count == LAST.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_tick  <= (w_count_nxt == LAST);
        end
    end

    assign sample_tick = r_tick;

endmodule

// File: rtl/wand_bus_tx.sv
// Wired-AND line transmitter: start bit, MSB-first data, stop bit, with
// per-bit read-back for arbitration and line-fault detection.
module wand_bus_tx
    import wand_bus_pkg::*;
#(
    parameter  int unsigned DATA_W     = DATA_W_DEF,
    parameter  int unsigned BIT_CYCLES = BIT_CYCLES_DEF,
    localparam int unsigned IDX_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic              bus_in,
    output logic              bus_drive_low,
    output logic              busy,
    output logic              done,
    output logic              arb_lost,
    output logic              bus_err,
    output logic [IDX_W-1:0]  lost_bit
);

    localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(DATA_W - 1);

    state_t             r_state;
    logic [DATA_W-1:0]  r_shift;
    logic [IDX_W-1:0]   r_bit_idx;
    logic               r_drive_low;
    logic               r_busy;
    logic               r_done;
    logic               r_arb_lost;
    logic               r_bus_err;
    logic [IDX_W-1:0]   r_lost_bit;

    logic               w_sample;
    logic               w_timer_clear;
    logic [DATA_W-1:0]  w_shift_nxt;

    assign w_timer_clear = (r_state == ST_IDLE);
    assign w_shift_nxt   = r_shift << 1;

    wand_bus_bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .clk         (clk),
        .rst         (rst),
        .clear       (w_timer_clear),
        .sample_tick (w_sample)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_bit_idx   <= '0;
            r_drive_low <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_arb_lost  <= 1'b0;
            r_bus_err   <= 1'b0;
            r_lost_bit  <= '0;
        end else begin
            r_done     <= 1'b0;
            r_arb_lost <= 1'b0;
            r_bus_err  <= 1'b0;

            unique case (r_state)
                ST_IDLE: begin
                    r_drive_low <= 1'b0;
                    r_busy      <= 1'b0;
                    // Only join when the line is currently idle (released).
                    if (start && (bus_in == BUS_RELEASED)) begin
                        r_state     <= ST_START;
                        r_shift     <= data_in;
                        r_bit_idx   <= MSB_IDX;
                        r_lost_bit  <= '0;
                        r_drive_low <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end

                ST_START: begin
                    if (w_sample) begin
                        if (bus_in == BUS_RELEASED) begin
                            r_state     <= ST_IDLE;
                            r_drive_low <= 1'b0;
                            r_busy      <= 1'b0;
                            r_bus_err   <= 1'b1;
                        end else begin
                            r_state     <= ST_DATA;
                            r_bit_idx   <= MSB_IDX;
                            r_drive_low <= ~r_shift[DATA_W-1];
                        end
                    end
                end

                ST_DATA: begin
                    if (w_sample) begin
                        if (!r_drive_low && (bus_in == BUS_LOW)) begin
                            // Released a 1 but someone else holds the line: back off.
                            r_state     <= ST_IDLE;
                            r_drive_low <= 1'b0;
                            r_busy      <= 1'b0;
                            r_arb_lost  <= 1'b1;
                            r_lost_bit  <= r_bit_idx;
                        end else if (r_drive_low && (bus_in == BUS_RELEASED)) begin
                            r_state     <= ST_IDLE;
                            r_drive_low <= 1'b0;
                            r_busy      <= 1'b0;
                            r_bus_err   <= 1'b1;
                        end else if (r_bit_idx == '0) begin
                            r_state     <= ST_STOP;
                            r_drive_low <= 1'b0;
                        end else begin
                            r_shift     <= w_shift_nxt;
                            r_bit_idx   <= r_bit_idx - IDX_W'(1);
                            r_drive_low <= ~w_shift_nxt[DATA_W-1];
                        end
                    end
                end

                ST_STOP: begin
                    if (w_sample) begin
                        r_state     <= ST_IDLE;
                        r_drive_low <= 1'b0;
                        r_busy      <= 1'b0;
                        if (bus_in == BUS_LOW) begin
                            r_bus_err <= 1'b1;
                        end else begin
                            r_done    <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_drive_low <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus_drive_low = r_drive_low;
    assign busy          = r_busy;
    assign done          = r_done;
    assign arb_lost      = r_arb_lost;
    assign bus_err       = r_bus_err;
    assign lost_bit      = r_lost_bit;

endmodule
